// File: rtl/readbuf_counters_pkg.sv
// Shared constants for the packet line buffer address/occupancy logic.
// Default geometry is 8 lines of 2 KiB each.
package readbuf_counters_pkg;

  localparam int LINE_AW_DEF = 3;
  localparam int CHAR_AW_DEF = 11;
  localparam int LINES_DEF   = 1 << LINE_AW_DEF;

  // Width of the {line, char} BRAM address shared by the wrapper and both FSMs
  function automatic int rbAddrW(input int lineAw, input int charAw);
    return lineAw + charAw;
  endfunction

  localparam int ADDR_W_DEF = rbAddrW(LINE_AW_DEF, CHAR_AW_DEF);

endpackage

// File: rtl/readbuf_counters_if.sv
// Handshake between the ingress write FSM, the read FSM and the line buffer counters.
// The master side is the FSM pair; the counters block is the slave.
interface readbuf_counters_if #(
  parameter int LINE_AW = readbuf_counters_pkg::LINE_AW_DEF,
  parameter int CHAR_AW = readbuf_counters_pkg::CHAR_AW_DEF
);
  localparam int ADDR_W = readbuf_counters_pkg::rbAddrW(LINE_AW, CHAR_AW);

  logic              wr_char_incr;
  logic              wr_newline;
  logic              wr_drop;
  logic [ADDR_W-1:0] wr_addr;
  logic              fullflag;
  logic              wr_ovf;
  logic              rd_char_incr;
  logic              rd_newline;
  logic [ADDR_W-1:0] rd_addr;
  logic              greenflag;
  logic              lastflag;
  logic [LINE_AW:0]  used_lines;

  modport master (
    output wr_char_incr, wr_newline, wr_drop, rd_char_incr, rd_newline,
    input  wr_addr, fullflag, wr_ovf, rd_addr, greenflag, lastflag, used_lines
  );

  modport slave (
    input  wr_char_incr, wr_newline, wr_drop, rd_char_incr, rd_newline,
    output wr_addr, fullflag, wr_ovf, rd_addr, greenflag, lastflag, used_lines
  );

endinterface

// File: rtl/readbuf_len_regfile.sv
// Per-line packet length store: one synchronous write port, one async read port.
// Kept in flops so lastflag sees the current read line's length with no latency.
module readbuf_len_regfile
  import readbuf_counters_pkg::*;
#(
  parameter int LINE_AW = LINE_AW_DEF,
  parameter int LEN_W   = CHAR_AW_DEF + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [LINE_AW-1:0] i_waddr,
  input  logic [LEN_W-1:0]   i_wdata,
  input  logic [LINE_AW-1:0] i_raddr,
  output logic [LEN_W-1:0]   o_rdata
);

  localparam int LINES = 1 << LINE_AW;

  logic [LEN_W-1:0] r_len [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) r_len[i] <= '0;
    end else if (i_we) begin
      r_len[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_len[i_raddr];

endmodule

// File: rtl/readbuf_counters.sv
// Line/character address generator and occupancy tracker for the packet line buffer.
// Writer fills and commits/drops whole lines; reader consumes committed lines in order.
module readbuf_counters
  import readbuf_counters_pkg::*;
#(
  parameter int LINE_AW = LINE_AW_DEF,
  parameter int CHAR_AW = CHAR_AW_DEF
) (
  input logic          clk,
  input logic          rst,
  readbuf_counters_if.slave bus
);

  localparam int LINES = 1 << LINE_AW;
  localparam int LEN_W = CHAR_AW + 1;
  localparam logic [LEN_W-1:0]   CHAR_MAX  = LEN_W'(1 << CHAR_AW);
  localparam logic [LINE_AW:0]   USED_FULL = (LINE_AW + 1)'(LINES);

  logic [LINE_AW-1:0] r_wrLine;
  logic [LEN_W-1:0]   r_wrCnt;
  logic               r_wrOvf;
  logic [LINE_AW-1:0] r_rdLine;
  logic [CHAR_AW-1:0] r_rdChar;
  logic [LINE_AW:0]   r_used;

  logic               w_full;
  logic               w_green;
  logic               w_wrAccept;
  logic               w_incOk;
  logic               w_incOvf;
  logic [LEN_W-1:0]   w_effLen;
  logic               w_endLine;
  logic               w_commit;
  logic [LEN_W-1:0]   w_lenRd;
  logic [LEN_W-1:0]   w_lenRdM1;
  logic               w_rdPop;
  logic               w_rdInc;

  assign w_full     = (r_used == USED_FULL);
  assign w_green    = (r_used != '0);
  assign w_wrAccept = !w_full;

  assign w_incOk    = w_wrAccept && bus.wr_char_incr && (r_wrCnt < CHAR_MAX);
  assign w_incOvf   = w_wrAccept && bus.wr_char_incr && !(r_wrCnt < CHAR_MAX);
  assign w_effLen   = r_wrCnt + {{CHAR_AW{1'b0}}, w_incOk};
  assign w_endLine  = w_wrAccept && (bus.wr_newline || bus.wr_drop);
  // A line that overflowed (earlier or on its final byte) or is empty is discarded
  assign w_commit   = w_wrAccept && bus.wr_newline && !bus.wr_drop &&
                      (w_effLen != '0) && !r_wrOvf && !w_incOvf;

  assign w_lenRdM1  = w_lenRd - LEN_W'(1);
  assign w_rdPop    = w_green && bus.rd_newline;
  assign w_rdInc    = w_green && bus.rd_char_incr && !bus.rd_newline &&
                      ({1'b0, r_rdChar} < w_lenRdM1);

  readbuf_len_regfile #(
    .LINE_AW (LINE_AW),
    .LEN_W   (LEN_W)
  ) u_lenRegfile (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_commit),
    .i_waddr (r_wrLine),
    .i_wdata (w_effLen),
    .i_raddr (r_rdLine),
    .o_rdata (w_lenRd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrLine <= '0;
      r_wrCnt  <= '0;
      r_wrOvf  <= 1'b0;
    end else if (w_endLine) begin
      r_wrCnt <= '0;
      r_wrOvf <= 1'b0;
      if (w_commit) r_wrLine <= r_wrLine + 1'b1;
    end else begin
      if (w_incOk)  r_wrCnt <= r_wrCnt + 1'b1;
      if (w_incOvf) r_wrOvf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdLine <= '0;
      r_rdChar <= '0;
    end else if (w_rdPop) begin
      r_rdChar <= '0;
      r_rdLine <= r_rdLine + 1'b1;
    end else if (w_rdInc) begin
      r_rdChar <= r_rdChar + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_used <= '0;
    end else begin
      case ({w_commit, w_rdPop})
        2'b10:   r_used <= r_used + 1'b1;
        2'b01:   r_used <= r_used - 1'b1;
        default: r_used <= r_used;
      endcase
    end
  end

  assign bus.wr_addr    = {r_wrLine, r_wrCnt[CHAR_AW-1:0]};
  assign bus.rd_addr    = {r_rdLine, r_rdChar};
  assign bus.fullflag   = w_full;
  assign bus.wr_ovf     = r_wrOvf;
  assign bus.greenflag  = w_green;
  assign bus.lastflag   = w_green && ({1'b0, r_rdChar} == w_lenRdM1);
  assign bus.used_lines = r_used;

endmodule

// File: tb/tb_readbuf_counters.sv
// Directed bench: default geometry (8 x 2048) plus a tiny-line instance (8 x 4) for overflow.
// Addresses for the big instance are line*2048 + char; for the small one line*4 + char.
module tb_readbuf_counters;

  logic clk;
  logic rst;

  int assertCount = 0;
  int failCount   = 0;

  readbuf_counters_if #(.LINE_AW(3), .CHAR_AW(11)) busA ();
  readbuf_counters_if #(.LINE_AW(3), .CHAR_AW(2))  busB ();

  readbuf_counters #(.LINE_AW(3), .CHAR_AW(11)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA.slave)
  );

  readbuf_counters #(.LINE_AW(3), .CHAR_AW(2)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of strobes on the selected instance, then release them
  task automatic applyStimulus(input bit selB, input bit wi, input bit wn, input bit wd,
                               input bit ri, input bit rn);
    if (selB) begin
      busB.wr_char_incr = wi; busB.wr_newline = wn; busB.wr_drop = wd;
      busB.rd_char_incr = ri; busB.rd_newline = rn;
    end else begin
      busA.wr_char_incr = wi; busA.wr_newline = wn; busA.wr_drop = wd;
      busA.rd_char_incr = ri; busA.rd_newline = rn;
    end
    @(posedge clk);
    #1;
    busA.wr_char_incr = 0; busA.wr_newline = 0; busA.wr_drop = 0;
    busA.rd_char_incr = 0; busA.rd_newline = 0;
    busB.wr_char_incr = 0; busB.wr_newline = 0; busB.wr_drop = 0;
    busB.rd_char_incr = 0; busB.rd_newline = 0;
  endtask

  initial begin
    rst = 1'b1;
    busA.wr_char_incr = 0; busA.wr_newline = 0; busA.wr_drop = 0;
    busA.rd_char_incr = 0; busA.rd_newline = 0;
    busB.wr_char_incr = 0; busB.wr_newline = 0; busB.wr_drop = 0;
    busB.rd_char_incr = 0; busB.rd_newline = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("rst_full",  32'(busA.fullflag),   0);
    checkOutput("rst_green", 32'(busA.greenflag),  0);
    checkOutput("rst_last",  32'(busA.lastflag),   0);
    checkOutput("rst_wradr", 32'(busA.wr_addr),    0);
    checkOutput("rst_rdadr", 32'(busA.rd_addr),    0);
    checkOutput("rst_used",  32'(busA.used_lines), 0);

    // Basic 4-byte packet, write then read
    repeat (4) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("p4_wradr", 32'(busA.wr_addr), 4);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("p4_used",  32'(busA.used_lines), 1);
    checkOutput("p4_green", 32'(busA.greenflag), 1);
    checkOutput("p4_wradr2", 32'(busA.wr_addr), 2048);
    checkOutput("p4_last0", 32'(busA.lastflag), 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("p4_rdadr", 32'(busA.rd_addr), 3);
    checkOutput("p4_last",  32'(busA.lastflag), 1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("p4_rdsat", 32'(busA.rd_addr), 3);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("p4_green0", 32'(busA.greenflag), 0);
    checkOutput("p4_rdadr2", 32'(busA.rd_addr), 2048);
    checkOutput("p4_used0",  32'(busA.used_lines), 0);
    checkOutput("p4_last1",  32'(busA.lastflag), 0);

    // Drop, empty commit, drop-over-newline priority
    repeat (5) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("drop_wradr", 32'(busA.wr_addr), 2053);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("drop_used",  32'(busA.used_lines), 0);
    checkOutput("drop_wradr2", 32'(busA.wr_addr), 2048);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("empty_used", 32'(busA.used_lines), 0);
    checkOutput("empty_wradr", 32'(busA.wr_addr), 2048);
    repeat (2) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkOutput("prio_used",  32'(busA.used_lines), 0);
    checkOutput("prio_wradr", 32'(busA.wr_addr), 2048);

    // Eight one-byte lines starting at line 1; write pointer wraps 7 -> 0 -> 1
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 1, 0, 0, 0);
      if (i == 6) begin
        checkOutput("fill7_wradr", 32'(busA.wr_addr), 0);
        checkOutput("fill7_full",  32'(busA.fullflag), 0);
        checkOutput("fill7_used",  32'(busA.used_lines), 7);
      end
    end
    checkOutput("fill8_full",  32'(busA.fullflag), 1);
    checkOutput("fill8_used",  32'(busA.used_lines), 8);
    checkOutput("fill8_wradr", 32'(busA.wr_addr), 2048);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("full_incblk", 32'(busA.wr_addr), 2048);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("full_nlblk", 32'(busA.used_lines), 8);
    checkOutput("full_last",  32'(busA.lastflag), 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("unfull_full",  32'(busA.fullflag), 0);
    checkOutput("unfull_used",  32'(busA.used_lines), 7);
    checkOutput("unfull_rdadr", 32'(busA.rd_addr), 4096);
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("rdwrap_rdadr", 32'(busA.rd_addr), 0);
    checkOutput("rdwrap_used",  32'(busA.used_lines), 1);

    // Two-byte line at line 1, then a 6-byte commit together with a pop
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("len2_used",  32'(busA.used_lines), 2);
    checkOutput("len2_wradr", 32'(busA.wr_addr), 4096);
    repeat (5) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 1);
    checkOutput("sim_used",  32'(busA.used_lines), 2);
    checkOutput("sim_wradr", 32'(busA.wr_addr), 6144);
    checkOutput("sim_rdadr", 32'(busA.rd_addr), 2048);
    checkOutput("sim_last",  32'(busA.lastflag), 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("len2_last",  32'(busA.lastflag), 1);
    checkOutput("len2_rdadr", 32'(busA.rd_addr), 2049);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("len6_rdadr", 32'(busA.rd_addr), 4096);
    checkOutput("len6_used",  32'(busA.used_lines), 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("len6_rdadr3", 32'(busA.rd_addr), 4099);
    checkOutput("len6_last",   32'(busA.lastflag), 0);

    // Tiny-line instance: 4 bytes fit, a 5th overflows and the line is discarded
    repeat (4) applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("b_cnt4_wradr", 32'(busB.wr_addr), 0);
    checkOutput("b_cnt4_ovf",   32'(busB.wr_ovf), 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("b_ovf",       32'(busB.wr_ovf), 1);
    checkOutput("b_ovf_wradr", 32'(busB.wr_addr), 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("b_disc_ovf",   32'(busB.wr_ovf), 0);
    checkOutput("b_disc_used",  32'(busB.used_lines), 0);
    checkOutput("b_disc_green", 32'(busB.greenflag), 0);
    repeat (4) applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("b_max_used",  32'(busB.used_lines), 1);
    checkOutput("b_max_wradr", 32'(busB.wr_addr), 4);
    repeat (3) applyStimulus(1, 0, 0, 0, 1, 0);
    checkOutput("b_max_rdadr", 32'(busB.rd_addr), 3);
    checkOutput("b_max_last",  32'(busB.lastflag), 1);

    // Asynchronous reset in the middle of a cycle, mid-read on instance A
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("arst_full",  32'(busA.fullflag),   0);
    checkOutput("arst_green", 32'(busA.greenflag),  0);
    checkOutput("arst_last",  32'(busA.lastflag),   0);
    checkOutput("arst_wradr", 32'(busA.wr_addr),    0);
    checkOutput("arst_rdadr", 32'(busA.rd_addr),    0);
    checkOutput("arst_used",  32'(busA.used_lines), 0);
    checkOutput("arst_b_used", 32'(busB.used_lines), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("post_green", 32'(busA.greenflag), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
